// File: rtl/tcm_boot_loader.sv
// Boot sequencer for riscv_tcm_top: streams an image into the TCM write port,
// pulses the core reset, runs the core until the halt instruction is fetched.
module tcm_boot_loader #(
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned MAX_WORDS    = 100,
  parameter logic [31:0] HALT_INST    = 32'h0000_8067,
  parameter int unsigned RUN_TIMEOUT  = 40000,
  parameter int unsigned RST_CYCLES   = 1,
  parameter int unsigned DRAIN_CYCLES = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        s_valid_i,
  input  logic [31:0] s_data_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  output logic [3:0]  tcm_we_o,
  output logic [31:0] tcm_addr_o,
  output logic [31:0] tcm_data_o,
  output logic        rst_cpu_o,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_inst_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        overflow_o,
  output logic [15:0] words_loaded_o,
  output logic [31:0] run_cycles_o
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMR_W = 32;

  localparam logic [CNT_W-1:0] LP_LAST_IDX  = CNT_W'(MAX_WORDS - 1);
  localparam logic [TMR_W-1:0] LP_RST_END   = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LP_DRAIN_END = TMR_W'(DRAIN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LP_TIMEOUT   = TMR_W'(RUN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CORE_RST, S_RUN, S_DRAIN, S_DONE, S_FAIL
  } state_t;

  state_t             r_state,    w_state;
  logic [TMR_W-1:0]   r_tmr,      w_tmr;
  logic               r_s_ready,  w_s_ready;
  logic [3:0]         r_we,       w_we;
  logic [31:0]        r_addr,     w_addr;
  logic [31:0]        r_data,     w_data;
  logic               r_rst_cpu,  w_rst_cpu;
  logic               r_busy,     w_busy;
  logic               r_done,     w_done;
  logic               r_timeout,  w_timeout;
  logic               r_overflow, w_overflow;
  logic [CNT_W-1:0]   r_words,    w_words;
  logic [31:0]        r_run,      w_run;

  logic w_beat;
  logic w_halt;

  assign w_beat = s_valid_i & r_s_ready;
  assign w_halt = fetch_valid_i && (fetch_inst_i == HALT_INST);

  // Next state and next register values; outputs are derived from the next state
  always_comb begin
    w_state    = r_state;
    w_we       = 4'h0;
    w_addr     = r_addr;
    w_data     = r_data;
    w_done     = r_done;
    w_timeout  = r_timeout;
    w_overflow = r_overflow;
    w_words    = r_words;
    w_run      = r_run;

    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          w_state    = S_LOAD;
          w_done     = 1'b0;
          w_timeout  = 1'b0;
          w_overflow = 1'b0;
          w_words    = '0;
          w_run      = '0;
        end
      end
      S_LOAD: begin
        if (w_beat) begin
          w_we    = 4'hf;
          w_addr  = BASE_ADDR + 32'({r_words, 2'b00});
          w_data  = s_data_i;
          w_words = r_words + CNT_W'(1);
          if (s_last_i) begin
            w_state = S_SETTLE;
          end else if (r_words == LP_LAST_IDX) begin
            w_state    = S_FAIL;
            w_overflow = 1'b1;
          end
        end
      end
      S_SETTLE: w_state = S_CORE_RST;
      S_CORE_RST: begin
        if (r_tmr == LP_RST_END) begin
          w_state = S_RUN;
          w_run   = 32'd1;
        end
      end
      S_RUN: begin
        // A halt in the timeout cycle still counts as a clean finish
        if (w_halt) begin
          w_state = S_DRAIN;
        end else if (r_run == LP_TIMEOUT) begin
          w_state   = S_FAIL;
          w_timeout = 1'b1;
        end else begin
          w_run = r_run + 32'd1;
        end
      end
      S_DRAIN: begin
        if (r_tmr == LP_DRAIN_END) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_tmr     = (w_state == r_state) ? r_tmr + TMR_W'(1) : '0;
    w_s_ready = (w_state == S_LOAD);
    w_rst_cpu = !((w_state == S_RUN) || (w_state == S_DRAIN));
    w_busy    = !((w_state == S_IDLE) || (w_state == S_DONE) || (w_state == S_FAIL));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      r_s_ready  <= 1'b0;
      r_we       <= 4'h0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rst_cpu  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_overflow <= 1'b0;
      r_words    <= '0;
      r_run      <= '0;
    end else begin
      r_state    <= w_state;
      r_tmr      <= w_tmr;
      r_s_ready  <= w_s_ready;
      r_we       <= w_we;
      r_addr     <= w_addr;
      r_data     <= w_data;
      r_rst_cpu  <= w_rst_cpu;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_timeout  <= w_timeout;
      r_overflow <= w_overflow;
      r_words    <= w_words;
      r_run      <= w_run;
    end
  end

  assign s_ready_o      = r_s_ready;
  assign tcm_we_o       = r_we;
  assign tcm_addr_o     = r_addr;
  assign tcm_data_o     = r_data;
  assign rst_cpu_o      = r_rst_cpu;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign timeout_o      = r_timeout;
  assign overflow_o     = r_overflow;
  assign words_loaded_o = r_words;
  assign run_cycles_o   = r_run;

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Bench for tcm_boot_loader: load/run scenario table, write scoreboard,
// and hand sequences for restart-while-busy and reset during a load.
module tb_tcm_boot_loader;

  localparam logic [31:0] BASE = 32'h100;
  localparam int          MAXW = 12;
  localparam logic [31:0] HALT = 32'h0000_8067;
  localparam int          TMO  = 50;
  localparam int          RSTC = 1;
  localparam int          DRN  = 5;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        s_valid_i = 1'b0;
  logic [31:0] s_data_i = '0;
  logic        s_last_i = 1'b0;
  logic        s_ready_o;
  logic [3:0]  tcm_we_o;
  logic [31:0] tcm_addr_o;
  logic [31:0] tcm_data_o;
  logic        rst_cpu_o;
  logic        fetch_valid_i = 1'b0;
  logic [31:0] fetch_inst_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;
  logic        overflow_o;
  logic [15:0] words_loaded_o;
  logic [31:0] run_cycles_o;

  tcm_boot_loader #(
    .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .HALT_INST(HALT),
    .RUN_TIMEOUT(TMO), .RST_CYCLES(RSTC), .DRAIN_CYCLES(DRN)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .tcm_we_o(tcm_we_o), .tcm_addr_o(tcm_addr_o), .tcm_data_o(tcm_data_o),
    .rst_cpu_o(rst_cpu_o), .fetch_valid_i(fetch_valid_i), .fetch_inst_i(fetch_inst_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .overflow_o(overflow_o),
    .words_loaded_o(words_loaded_o), .run_cycles_o(run_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int nwords, last_at, gaps, halt_at;
    int exp_words, exp_ovf, exp_run, exp_done, exp_to, exp_drain;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  logic [31:0] exp_addr = BASE;
  wr_t         q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Every TCM write must match the oldest accepted beat
  always @(negedge clk_i) begin
    if (tcm_we_o !== 4'h0) begin
      last_wr_cyc = cyc;
      if (q.size() == 0) begin
        check("wr_unexpected", 32'(tcm_we_o), 32'h0);
      end else begin
        wr_t e;
        e = q.pop_front();
        check("wr_we", 32'(tcm_we_o), 32'hf);
        check("wr_addr", tcm_addr_o, e.addr);
        check("wr_data", tcm_data_o, e.data);
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic last, input int gap,
                           input int limit, output logic ok);
    wr_t e;
    ok = 1'b0;
    s_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk_i); #1; end
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_i);
      if (s_ready_o === 1'b1) begin
        e.addr = exp_addr;
        e.data = d;
        q.push_back(e);
        exp_addr = exp_addr + 32'd4;
        ok = 1'b1;
      end
      @(posedge clk_i); #1;
      if (ok) break;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("start_ready", 32'(s_ready_o), 32'd1);
    check("start_busy", 32'(busy_o), 32'd1);
    check("start_flags", {29'd0, done_o, timeout_o, overflow_o}, 32'd0);
    check("start_words", 32'(words_loaded_o), 32'd0);
    check("start_run", run_cycles_o, 32'd0);
    exp_addr = BASE;
    @(posedge clk_i); #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic ok;
    int   limit;
    int   rc;
    do_start();
    for (int w = 1; w <= v.nwords; w++) begin
      send_word($urandom, (w == v.last_at), (v.gaps != 0) ? int'($urandom_range(0, 3)) : 0,
                (w <= v.exp_words) ? 20 : 5, ok);
      check($sformatf("accept_w%0d", w), 32'(ok), 32'(w <= v.exp_words));
    end
    if (v.exp_ovf != 0) begin
      @(negedge clk_i);
      check("ovf_flag", 32'(overflow_o), 32'd1);
      check("ovf_ready", 32'(s_ready_o), 32'd0);
      check("ovf_rst_cpu", 32'(rst_cpu_o), 32'd1);
      check("ovf_busy", 32'(busy_o), 32'd0);
      check("ovf_words", 32'(words_loaded_o), 32'(v.exp_words));
      @(posedge clk_i); #1;
      return;
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (rst_cpu_o === 1'b0) begin ok = 1'b1; break; end
    end
    check("core_release", 32'(ok), 32'd1);
    if (!ok) return;
    check("release_delay", 32'(cyc - last_wr_cyc), 32'(1 + RSTC));
    check("load_words", 32'(words_loaded_o), 32'(v.exp_words));
    check("load_ovf", 32'(overflow_o), 32'd0);
    check("run_ready", 32'(s_ready_o), 32'd0);
    limit = (v.halt_at > 0) ? v.halt_at : TMO;
    for (int k = 1; k <= limit; k++) begin
      if (k == v.halt_at) begin
        fetch_valid_i = 1'b1;
        fetch_inst_i  = HALT;
      end else begin
        fetch_valid_i = (k % 2 == 1);
        fetch_inst_i  = (k % 2 == 1) ? (HALT ^ 32'(k)) : HALT;
      end
      if (k == limit) check("run_cycles_last", run_cycles_o, 32'(k));
      @(negedge clk_i);
    end
    fetch_valid_i = 1'b0;
    fetch_inst_i  = '0;
    rc = 0;
    while (rst_cpu_o === 1'b0 && rc < 20) begin
      rc++;
      @(negedge clk_i);
    end
    check("drain_len", 32'(rc), 32'(v.exp_drain));
    check("end_run", run_cycles_o, 32'(v.exp_run));
    check("end_done", 32'(done_o), 32'(v.exp_done));
    check("end_timeout", 32'(timeout_o), 32'(v.exp_to));
    check("end_rst_cpu", 32'(rst_cpu_o), 32'd1);
    check("end_busy", 32'(busy_o), 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    vec_t rv;
    logic ok;
    vt[0] = '{12, 12, 0, 37, 12, 0, 37, 1, 0, DRN};
    vt[1] = '{10, 10, 1, 50, 10, 0, 50, 1, 0, DRN};
    vt[2] = '{3,  3,  1, 0,  3,  0, TMO, 0, 1, 0};
    vt[3] = '{13, 0,  0, 0,  12, 1, 0,  0, 0, 0};
    vt[4] = '{1,  1,  0, 1,  1,  0, 1,  1, 0, DRN};
    rv    = '{2,  2,  0, 5,  2,  0, 5,  1, 0, DRN};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 32'(s_ready_o), 32'd0);
    check("rst_we", 32'(tcm_we_o), 32'd0);
    check("rst_addr", tcm_addr_o, 32'd0);
    check("rst_data", tcm_data_o, 32'd0);
    check("rst_rst_cpu", 32'(rst_cpu_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_flags", {29'd0, done_o, timeout_o, overflow_o}, 32'd0);
    check("rst_words", 32'(words_loaded_o), 32'd0);
    check("rst_run", run_cycles_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // start during a load is ignored; reset right after beat 10 drops to IDLE
    do_start();
    for (int w = 1; w <= 10; w++) begin
      if (w == 6) begin
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
      end
      send_word($urandom, 1'b0, 0, 20, ok);
      check($sformatf("t6_accept_w%0d", w), 32'(ok), 32'd1);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    check("t6_words_pre", 32'(words_loaded_o), 32'd10);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t6_we", 32'(tcm_we_o), 32'd0);
    check("t6_rst_cpu", 32'(rst_cpu_o), 32'd1);
    check("t6_ready", 32'(s_ready_o), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_flags", {29'd0, done_o, timeout_o, overflow_o}, 32'd0);
    check("t6_words", 32'(words_loaded_o), 32'd0);
    check("t6_sb_drained", 32'(q.size()), 32'd0);
    @(posedge clk_i); #1;
    run_vec(rv);

    repeat (2) @(negedge clk_i);
    check("sb_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
